// File: rtl/uart_byte_fifo.sv
// Byte FIFO between a UART receiver and transmitter: edge-detected pushes, a
// three-state read FSM that hands one byte at a time to the transmitter.
// Optional: define UART_FIFO_ERR_DROP_EN to discard bytes received with rx_err=1.
module uart_byte_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_clk,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  input  logic              tx_clk,
  input  logic              tx_done,
  input  logic              clr,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  // Handshake: tx_start is held from SEND entry until tx_clk && tx_done; the
  // byte on tx_data is loaded once on SEND entry and stays stable meanwhile.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                rx_prev_q, rx_prev_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          mem_q [DEPTH];

  logic push_req;
  logic push_cand;
  logic push_ok;
  logic push_drop;
  logic pop;
  logic full_w;

  assign full_w   = (count_q == DEPTH_CNT);
  // Rising edge of rx_done as seen only on rx_clk ticks.
  assign push_req = rx_clk & rx_done & ~rx_prev_q;

`ifdef UART_FIFO_ERR_DROP_EN
  assign push_cand = push_req & ~rx_err;
`else
  assign push_cand = push_req;
`endif

  assign push_ok   = push_cand & ~full_w;
  assign push_drop = push_cand & full_w;
  assign pop       = (state_q == ST_SEND) & tx_start_q & tx_clk & tx_done;

  always_comb begin
    rx_prev_d = rx_prev_q;
    if (rx_clk) begin
      rx_prev_d = rx_done;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop) begin
          state_d    = ST_GAP;
          tx_start_d = 1'b0;
        end else begin
          tx_start_d = 1'b1;
          if (!tx_start_q) begin
            tx_data_d = mem_q[rd_ptr_q];
          end
        end
      end
      ST_GAP: begin
        // Wait for tx_done to fall so one send yields exactly one pop.
        if (tx_clk && !tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
    if (clr) begin
      state_d    = ST_IDLE;
      tx_start_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | push_drop;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_prev_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_prev_q  <= rx_prev_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Data array carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo: a depth-16 instance for most
// scenarios plus a depth-4 instance (enabled on demand) for full/overflow.
module tb_uart_byte_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_clk = 1'b0, rx_done = 1'b0, rx_err = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_clk = 1'b0, tx_done = 1'b0, clr = 1'b0;
  logic       en2 = 1'b0;

  logic       tx_start, empty, full, overflow;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic [1:0] dbg_state;

  logic       u2_tx_start, u2_empty, u2_full, u2_overflow;
  logic [7:0] u2_tx_data;
  logic [2:0] u2_count;
  logic [1:0] u2_dbg_state;
  logic       u2_rx_done, u2_tx_done;

  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int checks = 0;
  int failures = 0;

  assign u2_rx_done = rx_done & en2;
  assign u2_tx_done = tx_done & en2;

  always #5 clk = ~clk;

  uart_byte_fifo #(.ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .rx_clk(rx_clk), .rx_done(rx_done), .rx_data(rx_data),
    .rx_err(rx_err), .tx_clk(tx_clk), .tx_done(tx_done), .clr(clr),
    .tx_start(tx_start), .tx_data(tx_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .dbg_state(dbg_state)
  );

  uart_byte_fifo #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .rx_clk(rx_clk), .rx_done(u2_rx_done), .rx_data(rx_data),
    .rx_err(rx_err), .tx_clk(tx_clk), .tx_done(u2_tx_done), .clr(clr),
    .tx_start(u2_tx_start), .tx_data(u2_tx_data), .count(u2_count), .empty(u2_empty),
    .full(u2_full), .overflow(u2_overflow), .dbg_state(u2_dbg_state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic err);
`ifdef UART_FIFO_ERR_DROP_EN
    if (!err) exp_q.push_back(b);
`else
    exp_q.push_back(b);
`endif
    rx_clk = 1'b1; rx_done = 1'b1; rx_data = b; rx_err = err;
    step();
    rx_done = 1'b0; rx_err = 1'b0;
    step();
    rx_clk = 1'b0;
  endtask

  task automatic wait_tx_start();
    int n = 0;
    while (!tx_start && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL wait_tx_start: tx_start=%b after %0d clk, required 1", tx_start, n);
    end
  endtask

  task automatic send_one();
    logic [7:0] e;
    wait_tx_start();
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL send_unexpected: tx_data=%02h sent with empty scoreboard", tx_data);
    end else begin
      e = exp_q.pop_front();
      if (tx_data !== e) begin
        failures++;
        $display("FAIL send_data: tx_data=%02h required %02h", tx_data, e);
      end
    end
    if (en2 && exp2_q.size() != 0) begin
      e = exp2_q.pop_front();
      checks++;
      if (u2_tx_start !== 1'b1 || u2_tx_data !== e) begin
        failures++;
        $display("FAIL send_data_d4: tx_start=%b tx_data=%02h required 1/%02h",
                 u2_tx_start, u2_tx_data, e);
      end
    end
    tx_clk = 1'b1; tx_done = 1'b1;
    step();
    checks++;
    if (tx_start !== 1'b0) begin
      failures++;
      $display("FAIL send_ack_drop: tx_start=%b required 0", tx_start);
    end
    tx_done = 1'b0;
    step();
    tx_clk = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || count !== 5'd0 || empty !== 1'b1 ||
        full !== 1'b0 || overflow !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values: start=%b data=%02h count=%0d empty=%b full=%b ovf=%b st=%0d required 0/00/0/1/0/0/0",
               tx_start, tx_data, count, empty, full, overflow, dbg_state);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    rx_clk = 1'b1; rx_done = 1'b1; rx_data = 8'h41; rx_err = 1'b0;
    exp_q.push_back(8'h41);
    step();
    checks++;
    if (count !== 5'd1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL latency_push: count=%0d tx_start=%b required 1/0", count, tx_start);
    end
    rx_done = 1'b0;
    step();
    checks++;
    if (tx_start !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: tx_start=%b one clk after push, required 0", tx_start);
    end
    rx_clk = 1'b0;
    step();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h41 || count !== 5'd1) begin
      failures++;
      $display("FAIL latency_two_clk: tx_start=%b tx_data=%02h count=%0d required 1/41/1",
               tx_start, tx_data, count);
    end
    send_one();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL latency_drain: count=%0d empty=%b required 0/1", count, empty);
    end
  endtask

  task automatic test_held_rx_done();
    rx_data = 8'h55; rx_done = 1'b1;
    exp_q.push_back(8'h55);
    for (int i = 0; i < 5; i++) begin
      rx_clk = 1'b1; step();
      rx_clk = 1'b0; step();
    end
    checks++;
    if (count !== 5'd1) begin
      failures++;
      $display("FAIL held_single_push: count=%0d required 1", count);
    end
    rx_done = 1'b0; rx_clk = 1'b1; step(); rx_clk = 1'b0;
    send_one();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL held_drain: empty=%b required 1", empty);
    end
  endtask

  task automatic test_overflow();
    en2 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (exp2_q.size() < 4) exp2_q.push_back(8'(i));
      push_byte(8'(i), 1'b0);
      if (i == 4) begin
        checks++;
        if (u2_full !== 1'b1 || u2_count !== 3'd4 || u2_overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full_at_4: full=%b count=%0d ovf=%b required 1/4/0",
                   u2_full, u2_count, u2_overflow);
        end
      end
    end
    checks++;
    if (u2_overflow !== 1'b1 || u2_count !== 3'd4 || u2_full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drop_5th: ovf=%b count=%0d full=%b required 1/4/1",
               u2_overflow, u2_count, u2_full);
    end
    checks++;
    if (overflow !== 1'b0 || count !== 5'd5) begin
      failures++;
      $display("FAIL ovf_deep_fifo: ovf=%b count=%0d required 0/5", overflow, count);
    end
    for (int i = 0; i < 5; i++) send_one();
    checks++;
    if (u2_overflow !== 1'b1 || u2_empty !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b empty=%b empty16=%b required 1/1/1",
               u2_overflow, u2_empty, empty);
    end
    clr = 1'b1; step(); clr = 1'b0;
    checks++;
    if (u2_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: ovf=%b required 0", u2_overflow);
    end
    en2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    push_byte(8'h10, 1'b0);
    push_byte(8'h11, 1'b0);
    wait_tx_start();
    checks++;
    if (count !== 5'd2) begin
      failures++;
      $display("FAIL b2b_pre_count: count=%0d required 2", count);
    end
    e = exp_q.pop_front();
    checks++;
    if (tx_data !== e) begin
      failures++;
      $display("FAIL b2b_head: tx_data=%02h required %02h", tx_data, e);
    end
    rx_clk = 1'b1; rx_done = 1'b1; rx_data = 8'h12;
    tx_clk = 1'b1; tx_done = 1'b1;
    exp_q.push_back(8'h12);
    step();
    checks++;
    if (count !== 5'd2 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL b2b_push_pop: count=%0d tx_start=%b required 2/0", count, tx_start);
    end
    rx_done = 1'b0; tx_done = 1'b0;
    step();
    rx_clk = 1'b0; tx_clk = 1'b0;
    send_one();
    send_one();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain: empty=%b required 1", empty);
    end
  endtask

  task automatic test_reset_mid_send();
    push_byte(8'h21, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h23, 1'b0);
    wait_tx_start();
    checks++;
    if (count !== 5'd3) begin
      failures++;
      $display("FAIL rst_pre_count: count=%0d required 3", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_start !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_async: tx_start=%b count=%0d empty=%b tx_data=%02h required 0/0/1/00",
               tx_start, count, empty, tx_data);
    end
    exp_q.delete();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL rst_after_release: count=%0d empty=%b tx_start=%b required 0/1/0",
               count, empty, tx_start);
    end
  endtask

  task automatic test_rx_err();
    push_byte(8'h7E, 1'b1);
`ifdef UART_FIFO_ERR_DROP_EN
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL err_drop: count=%0d ovf=%b required 0/0", count, overflow);
    end
`else
    checks++;
    if (count !== 5'd1) begin
      failures++;
      $display("FAIL err_store: count=%0d required 1", count);
    end
    send_one();
`endif
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      push_byte(b, 1'b0);
    end
    for (int i = 0; i < n; i++) send_one();
    checks++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: empty=%b left=%0d required 1/0", empty, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_held_rx_done();
    test_overflow();
    test_back_to_back();
    test_reset_mid_send();
    test_rx_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo.md
UART_BYTE_FIFO -- requirements
Module: uart_byte_fifo

Interface
REQ-001 Parameter ADDR_W, default 4, meaning log2 of FIFO depth (depth = 2^ADDR_W bytes, ADDR_W 2..8).
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_clk  input  1  one-clk-wide receive-side tick qualifier from the baud generator.
REQ-005 rx_done  input  1  byte-received indication from the UART receiver, sampled only on rx_clk cycles.
REQ-006 rx_data  input  8  received byte, valid while rx_done=1.
REQ-007 rx_err  input  1  framing error for the byte on rx_data, valid while rx_done=1.
REQ-008 tx_clk  input  1  one-clk-wide transmit-side tick qualifier.
REQ-009 tx_done  input  1  byte-sent indication from the UART transmitter, sampled only on tx_clk cycles.
REQ-010 clr  input  1  synchronous flush, one clk.
REQ-011 tx_start  output  1  request to the transmitter; held until the transmitter acknowledges with tx_done.
REQ-012 tx_data  output  8  byte to send, stable while tx_start=1.
REQ-013 count  output  ADDR_W+1  bytes stored, including the byte being sent.
REQ-014 empty / full  output  1 each  count==0 / count==2^ADDR_W.
REQ-015 overflow  output  1  sticky, set when a byte is dropped because the FIFO is full.

Function
REQ-016 Push on the clk where rx_clk=1, rx_done=1, and the previous rx_clk-qualified sample of rx_done was 0 (rising edge in the tick domain); a held rx_done SHALL push once.
REQ-017 A push SHALL write rx_data at the write pointer, advance the pointer modulo 2^ADDR_W, and increment count.
REQ-018 A push while full SHALL be discarded, leave pointers/count unchanged, and set overflow.
REQ-019 Read FSM states: IDLE, SEND, GAP.
REQ-020 IDLE -> SEND when count!=0; tx_start=1 and tx_data=head byte from the next clk.
REQ-021 SEND -> GAP on tx_clk=1 with tx_done=1; same clk: tx_start<=0, read pointer advances modulo depth, count decrements.
REQ-022 GAP -> IDLE on the first tx_clk=1 with tx_done=0, so one send SHALL produce exactly one pop.
REQ-023 A push and a pop on the same clk SHALL leave count unchanged and both pointers advance.
REQ-024 The head byte SHALL NOT be overwritten while in SEND; full is computed on count, which includes the head.
REQ-025 clr SHALL empty the FIFO, set FSM to IDLE, drop tx_start, and clear overflow the next clk. It SHALL override a simultaneous push or pop.
REQ-026 Latency: a byte pushed into an empty FIFO in IDLE SHALL raise tx_start 2 clk after the push clk.
REQ-027 Storage is inferred RAM or registers, with no reset on the data array; tx_data is registered.

Reset
REQ-028 On rst=1, immediately and regardless of clk: tx_start=0, tx_data=0, count=0, empty=1, full=0, overflow=0, pointers=0, FSM=IDLE, and the rx edge-detect history cleared to 0.
REQ-029 rst asserted mid-send SHALL drop tx_start asynchronously. After release, the FIFO restarts empty.

Configuration
REQ-030 Macro UART_FIFO_ERR_DROP_EN defined: a byte with rx_err=1 at push time SHALL NOT be stored and SHALL NOT set overflow.
REQ-031 Macro UART_FIFO_ERR_DROP_EN undefined: rx_err SHALL be ignored, and errored bytes are stored like any other byte.

Verification
REQ-032 Push 0x41 into an empty FIFO, ADDR_W=4; tx_done held low -> tx_start=1 and tx_data=0x41 2 clk after the push, count=1.
REQ-033 rx_done held high across 5 rx_clk ticks with 0x55 -> exactly one push, count=1.
REQ-034 ADDR_W=2; push 0x01..0x05 with the transmitter stalled -> full=1 after the 4th push, 5th byte dropped, overflow=1, bytes sent in order 0x01..0x04.
REQ-035 Push coincident with a tx_done pop at count=2 -> count stays 2 and the next tx_data is the correct successor byte.
REQ-036 Assert rst while in SEND with 3 bytes queued -> tx_start=0 before the next posedge, then count=0 and empty=1 after release.
REQ-037 Push 0x7E with rx_err=1 -> count=0 with UART_FIFO_ERR_DROP_EN defined; count=1 and 0x7E sent without it.
